// File: rtl/netbus_pkt_fifo.sv
// netbus_pkt_fifo: store-and-forward flit FIFO that releases only complete packets and drops aborted or oversized ones
module netbus_pkt_fifo #(
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [DATA_WIDTH*9+13:0]  S_DATA,
    input  logic                      S_VALID,
    output logic                      S_READY,
    output logic [DATA_WIDTH*9+13:0]  M_DATA,
    output logic                      M_VALID,
    input  logic                      M_READY,
    output logic [DEPTH_LOG2:0]       PKT_COUNT,
    output logic [15:0]               DROP_COUNT
);
    localparam int W = DATA_WIDTH*9+14;
    localparam int P = DEPTH_LOG2+1;
    localparam int DEPTH = 2**DEPTH_LOG2;

    typedef enum logic {ACCEPT, DISCARD} state_t;

    state_t         state_q, state_d;
    logic [P-1:0]   wr_q, wr_d, cm_q, cm_d, rd_q, rd_d, pkt_q, pkt_d;
    logic [15:0]    drop_q, drop_d;
    logic [W-1:0]   mem [DEPTH];
    logic           full, oversize, s_fire, m_fire, s_last, s_abort, wr_en, commit, drop;

    assign s_last   = S_DATA[13];
    assign s_abort  = S_DATA[12];
    assign full     = (wr_q - rd_q) == P'(DEPTH);
    // A full buffer with no committed packet can only hold the current, oversized packet
    assign oversize = full && pkt_q == '0;
    assign s_fire   = S_VALID && S_READY;
    assign m_fire   = M_VALID && M_READY;
    assign wr_en    = s_fire && state_q == ACCEPT && !oversize && !s_abort;
    assign commit   = wr_en && s_last;
    assign drop     = s_fire && state_q == ACCEPT && (oversize || s_abort);

    always_ff @(posedge CLK) begin
        if (RESET) state_q <= ACCEPT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = (s_fire && (s_last || s_abort)) ? ACCEPT :
                  (s_fire && state_q == ACCEPT && oversize) ? DISCARD : state_q;
    end

    always_comb begin
        S_READY = state_q == DISCARD || !full || oversize;
        M_VALID = rd_q != cm_q;
        M_DATA  = mem[rd_q[DEPTH_LOG2-1:0]];
    end

    always_comb begin
        wr_d   = drop ? cm_q : wr_en ? wr_q + 1'b1 : wr_q;
        cm_d   = commit ? wr_q + 1'b1 : cm_q;
        rd_d   = m_fire ? rd_q + 1'b1 : rd_q;
        pkt_d  = pkt_q + P'(commit) - P'(m_fire && M_DATA[13]);
        drop_d = (drop && drop_q != '1) ? drop_q + 1'b1 : drop_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_q   <= '0;
            cm_q   <= '0;
            rd_q   <= '0;
            pkt_q  <= '0;
            drop_q <= '0;
        end else begin
            wr_q   <= wr_d;
            cm_q   <= cm_d;
            rd_q   <= rd_d;
            pkt_q  <= pkt_d;
            drop_q <= drop_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_q[DEPTH_LOG2-1:0]] <= S_DATA;
    end

    assign PKT_COUNT  = pkt_q;
    assign DROP_COUNT = drop_q;
endmodule
